// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one pipelined divider among NUM_REQ requesters.
// Each granted request is registered onto the divider's AXI-stream input channels
// and its requester index is queued in a tag FIFO. Results come back in issue
// order, so each result is routed to the requester at the head of that FIFO.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_divisor/  per-requester request, operands packed by slice
//   req_dividend
//   req_ready               one-hot grant (combinational)
//   s_axis_divisor_*        divisor channel to the divider
//   s_axis_dividend_*       dividend channel to the divider
//   m_axis_dout_*           divider result, no backpressure
//   rsp_data / rsp_valid    registered result and one-hot owner pulse
//   outstanding             number of divisions in flight
//   err_underflow           sticky: a result arrived with no pending tag
module divider_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DIVISOR_W  = 32,
   parameter int unsigned DIVIDEND_W = 32,
   parameter int unsigned DOUT_W     = 48,
   parameter int unsigned MAX_OUT    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DIVISOR_W-1:0]  req_divisor,
   input  logic [NUM_REQ*DIVIDEND_W-1:0] req_dividend,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DIVISOR_W-1:0]          s_axis_divisor_tdata,
   output logic                          s_axis_divisor_tvalid,
   output logic [DIVIDEND_W-1:0]         s_axis_dividend_tdata,
   output logic                          s_axis_dividend_tvalid,
   input  logic [DOUT_W-1:0]             m_axis_dout_tdata,
   input  logic                          m_axis_dout_tvalid,
   output logic [DOUT_W-1:0]             rsp_data,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [$clog2(MAX_OUT):0]      outstanding,
   output logic                          err_underflow
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned AW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;

   logic [PTR_W-1:0]      r_rr_ptr;
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CNT_W-1:0]      r_outstanding;
   logic [PTR_W-1:0]      r_tag_mem [MAX_OUT];
   logic [DIVISOR_W-1:0]  r_divisor;
   logic [DIVIDEND_W-1:0] r_dividend;
   logic                  r_issue;
   logic [DOUT_W-1:0]     r_rsp_data;
   logic [NUM_REQ-1:0]    r_rsp_valid;
   logic                  r_err;

   logic                  w_room;
   logic                  w_push;
   logic                  w_pop;
   logic [NUM_REQ-1:0]    w_grant;
   logic [PTR_W-1:0]      w_grant_idx;
   logic [PTR_W-1:0]      w_head_tag;
   logic [DIVISOR_W-1:0]  w_sel_divisor;
   logic [DIVIDEND_W-1:0] w_sel_dividend;

   // A returning result frees a slot in the same cycle, so a full FIFO can still grant.
   assign w_room     = (r_outstanding < CNT_W'(MAX_OUT)) || m_axis_dout_tvalid;
   assign w_pop      = m_axis_dout_tvalid && (r_outstanding != '0);
   assign w_head_tag = r_tag_mem[r_rd_ptr];

   // Round-robin search starting at r_rr_ptr; first valid requester wins.
   always_comb begin : p_grant
      int unsigned j;
      j              = 0;
      w_push         = 1'b0;
      w_grant        = '0;
      w_grant_idx    = '0;
      w_sel_divisor  = '0;
      w_sel_dividend = '0;
      if (w_room) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_push && req_valid[j]) begin
               w_push         = 1'b1;
               w_grant[j]     = 1'b1;
               w_grant_idx    = PTR_W'(j);
               w_sel_divisor  = req_divisor[j*DIVISOR_W +: DIVISOR_W];
               w_sel_dividend = req_dividend[j*DIVIDEND_W +: DIVIDEND_W];
            end
         end
      end
   end

   assign req_ready = w_grant;

   // Tag storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (w_push) r_tag_mem[r_wr_ptr] <= w_grant_idx;
   end

   // Issue path, tag pointers, response path and in-flight counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_outstanding <= '0;
         r_divisor     <= '0;
         r_dividend    <= '0;
         r_issue       <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_valid   <= '0;
         r_err         <= 1'b0;
      end else begin
         r_issue <= w_push;
         if (w_push) begin
            r_divisor  <= w_sel_divisor;
            r_dividend <= w_sel_dividend;
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_rr_ptr   <= (32'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + AW'(1);
            r_rsp_data  <= m_axis_dout_tdata;
            r_rsp_valid <= NUM_REQ'(1) << w_head_tag;
         end else begin
            r_rsp_valid <= '0;
         end
         if (m_axis_dout_tvalid && (r_outstanding == '0)) r_err <= 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   assign s_axis_divisor_tdata   = r_divisor;
   assign s_axis_divisor_tvalid  = r_issue;
   assign s_axis_dividend_tdata  = r_dividend;
   assign s_axis_dividend_tvalid = r_issue;
   assign rsp_data               = r_rsp_data;
   assign rsp_valid              = r_rsp_valid;
   assign outstanding            = r_outstanding;
   assign err_underflow          = r_err;

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter: a driver issues directed and random
// cycles and pushes expected issues/responses; a monitor compares them.
module tb_divider_arbiter;

   localparam int NR  = 4;
   localparam int DVW = 32;
   localparam int DDW = 32;
   localparam int OW  = 48;
   localparam int MO  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*DVW-1:0] req_divisor;
   logic [NR*DDW-1:0] req_dividend;
   logic [NR-1:0]     req_ready;
   logic [DVW-1:0]    s_axis_divisor_tdata;
   logic              s_axis_divisor_tvalid;
   logic [DDW-1:0]    s_axis_dividend_tdata;
   logic              s_axis_dividend_tvalid;
   logic [OW-1:0]     m_axis_dout_tdata;
   logic              m_axis_dout_tvalid;
   logic [OW-1:0]     rsp_data;
   logic [NR-1:0]     rsp_valid;
   logic [4:0]        outstanding;
   logic              err_underflow;

   divider_arbiter #(.NUM_REQ(NR), .DIVISOR_W(DVW), .DIVIDEND_W(DDW),
                     .DOUT_W(OW), .MAX_OUT(MO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_divisor(req_divisor), .req_dividend(req_dividend),
      .req_ready(req_ready),
      .s_axis_divisor_tdata(s_axis_divisor_tdata), .s_axis_divisor_tvalid(s_axis_divisor_tvalid),
      .s_axis_dividend_tdata(s_axis_dividend_tdata), .s_axis_dividend_tvalid(s_axis_dividend_tvalid),
      .m_axis_dout_tdata(m_axis_dout_tdata), .m_axis_dout_tvalid(m_axis_dout_tvalid),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid),
      .outstanding(outstanding), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   // Reference model state
   int                  m_rr;
   int                  tag_q[$];
   logic [63:0]         iss_q[$];
   logic [NR+OW-1:0]    rsp_q[$];
   bit                  m_err;
   bit                  rand_ops;
   int                  n_checks;
   int                  n_errors;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input logic dv);
      if (v == '0) return -1;
      if (!(tag_q.size() < MO || dv)) return -1;
      for (int k = 0; k < NR; k++)
         if (v[(m_rr + k) % NR]) return (m_rr + k) % NR;
      return -1;
   endfunction

   // One clock cycle of stimulus plus model update.
   task automatic step(input logic [NR-1:0] v, input logic dv, input logic [OW-1:0] dd);
      int g;
      logic [NR-1:0] exp_rdy;
      @(negedge clk);
      check("outstanding", 64'(outstanding), 64'(tag_q.size()));
      check("err_underflow", 64'(err_underflow), 64'(m_err));
      req_valid = v;
      if (rand_ops) begin
         for (int i = 0; i < NR; i++) begin
            req_divisor[i*DVW +: DVW]  = $urandom;
            req_dividend[i*DDW +: DDW] = $urandom;
         end
      end
      m_axis_dout_tvalid = dv;
      m_axis_dout_tdata  = dd;
      #1;
      g = pick(v, dv);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (dv) begin
         if (tag_q.size() > 0) begin
            logic [NR-1:0] oh;
            oh = '0;
            oh[tag_q.pop_front()] = 1'b1;
            rsp_q.push_back({oh, dd});
         end else begin
            m_err = 1'b1;
         end
      end
      if (g >= 0) begin
         iss_q.push_back({req_divisor[g*DVW +: DVW], req_dividend[g*DDW +: DDW]});
         tag_q.push_back(g);
         m_rr = (g + 1) % NR;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      m_axis_dout_tvalid = 1'b0;
      m_axis_dout_tdata = '0;
      #1;
      check("rst_divisor", 64'(s_axis_divisor_tdata), 64'(0));
      check("rst_dividend", 64'(s_axis_dividend_tdata), 64'(0));
      check("rst_tvalid", 64'({s_axis_divisor_tvalid, s_axis_dividend_tvalid}), 64'(0));
      check("rst_rsp_data", 64'(rsp_data), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_outstanding", 64'(outstanding), 64'(0));
      check("rst_err", 64'(err_underflow), 64'(0));
      tag_q.delete();
      m_rr  = 0;
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: exactly one-cycle latency, so every expected item must appear on the next edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (s_axis_divisor_tvalid || s_axis_dividend_tvalid || iss_q.size() > 0) begin
            if (iss_q.size() == 0) begin
               check("issue_unexpected", 64'({s_axis_divisor_tvalid, s_axis_dividend_tvalid}), 64'(0));
            end else begin
               logic [63:0] e;
               e = iss_q.pop_front();
               check("issue_tvalid", 64'({s_axis_divisor_tvalid, s_axis_dividend_tvalid}), 64'(3));
               check("issue_data", {s_axis_divisor_tdata, s_axis_dividend_tdata}, e);
            end
         end
         if (rsp_valid != '0 || rsp_q.size() > 0) begin
            if (rsp_q.size() == 0) begin
               check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
               logic [NR+OW-1:0] r;
               r = rsp_q.pop_front();
               check("rsp_valid", 64'(rsp_valid), 64'(r[NR+OW-1:OW]));
               check("rsp_data", 64'(rsp_data), 64'(r[OW-1:0]));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_errors = 0;
      m_rr = 0; m_err = 1'b0; rand_ops = 1'b1;
      rst_n = 1'b0;
      req_valid = '0; req_divisor = '0; req_dividend = '0;
      m_axis_dout_tvalid = 1'b0; m_axis_dout_tdata = '0;
      do_reset();

      // Round robin with all requesters held high, then reset mid-operation.
      repeat (5) step(4'b1111, 1'b0, '0);
      step(4'b0000, 1'b0, '0);
      check("rr_outstanding5", 64'(outstanding), 64'(5));
      do_reset();
      step(4'b1111, 1'b0, '0);
      check("post_reset_grant0", 64'(req_ready), 64'(4'b0001));
      step(4'b0000, 1'b1, 48'h1234_5678_9ABC);
      step(4'b0000, 1'b0, '0);

      // Single requester 2: 100 / 7.
      rand_ops = 1'b0;
      req_divisor  = '0;
      req_dividend = '0;
      req_divisor[2*DVW +: DVW]  = 32'd7;
      req_dividend[2*DDW +: DDW] = 32'd100;
      step(4'b0100, 1'b0, '0);
      check("single_ready", 64'(req_ready), 64'(4'b0100));
      rand_ops = 1'b1;
      step(4'b0000, 1'b0, '0);
      step(4'b0000, 1'b1, 48'h000E_0000_0002);
      step(4'b0000, 1'b0, '0);
      check("single_rsp", 64'({rsp_valid, rsp_data}), {12'h0, 4'b0100, 48'h000E_0000_0002});

      // Ordering 3,1,2.
      step(4'b1000, 1'b0, '0);
      step(4'b0010, 1'b0, '0);
      step(4'b0100, 1'b0, '0);
      repeat (3) step(4'b0000, 1'b1, 48'(({$urandom, $urandom})));
      step(4'b0000, 1'b0, '0);

      // Full condition.
      repeat (16) step(4'b1111, 1'b0, '0);
      step(4'b1111, 1'b0, '0);
      check("full_no_grant", 64'(req_ready), 64'(0));
      step(4'b1111, 1'b1, 48'h0000_0000_0ABC);
      step(4'b0000, 1'b0, '0);
      check("full_stays16", 64'(outstanding), 64'(16));
      while (tag_q.size() > 0) step(4'b0000, 1'b1, 48'(({$urandom, $urandom})));

      // Underflow: sticky until reset.
      step(4'b0000, 1'b1, 48'h0000_DEAD_BEEF);
      repeat (3) step(4'b0000, 1'b0, '0);
      check("underflow_sticky", 64'(err_underflow), 64'(1));
      do_reset();

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         logic dv;
         dv = (tag_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
         step(4'($urandom_range(0, 15)), dv, 48'(({$urandom, $urandom})));
      end
      while (tag_q.size() > 0) step(4'b0000, 1'b1, 48'(({$urandom, $urandom})));
      step(4'b0000, 1'b0, '0);
      step(4'b0000, 1'b0, '0);
      check("drain_iss_q", 64'(iss_q.size()), 64'(0));
      check("drain_rsp_q", 64'(rsp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
